// File: rtl/datapath_core_pkg.sv
// datapath_core shared definitions: ALU/bus codes, reg_sel bits.
// Shared with the control unit.
package datapath_core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [7:0] {
    ALU_CLEAR = 8'd0,
    ALU_INC   = 8'd1,
    ALU_DEC   = 8'd2,
    ALU_ADD   = 8'd3,
    ALU_SUB   = 8'd4,
    ALU_MUL2  = 8'd5,
    ALU_MUL4  = 8'd6,
    ALU_DIV16 = 8'd7,
    ALU_LOAD  = 8'd8,
    ALU_NOP   = 8'd9
  } alu_op_e;

  typedef enum logic [7:0] {
    BUS_DRAM = 8'd0,
    BUS_IRAM = 8'd1,
    BUS_DI   = 8'd2,
    BUS_RI   = 8'd3,
    BUS_BI   = 8'd4,
    BUS_S    = 8'd5,
    BUS_C1   = 8'd6,
    BUS_C2   = 8'd7,
    BUS_AR   = 8'd8,
    BUS_AC   = 8'd9,
    BUS_PC   = 8'd10,
    BUS_IR   = 8'd11
  } bus_src_e;

  localparam int RS_IR = 0;
  localparam int RS_DI = 1;
  localparam int RS_RI = 2;
  localparam int RS_BI = 3;
  localparam int RS_S  = 4;
  localparam int RS_C1 = 5;
  localparam int RS_C2 = 6;
  localparam int RS_AR = 7;
  localparam int RS_PC = 8;
  localparam int RS_N  = 9;

endpackage

// File: rtl/datapath_core_if.sv
// datapath_core control word and memory port bundle.
// master = control unit side, slave = datapath.
interface datapath_core_if
  import datapath_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [7:0]        alu_sel;
  logic [7:0]        bus_sel;
  logic [RS_N-1:0]   reg_sel;
  logic              pc_inc;
  logic [DATA_W-1:0] iram_rdata;
  logic [DATA_W-1:0] dram_rdata;
  logic [ADDR_W-1:0] iram_addr;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic [31:0]       ir;
  logic              z;
  logic              c;
  logic [DATA_W-1:0] ac;

  modport master (
    output alu_sel, bus_sel, reg_sel, pc_inc,
    output iram_rdata, dram_rdata,
    input  iram_addr, dram_addr, dram_wdata,
    input  ir, z, c, ac
  );

  modport slave (
    input  alu_sel, bus_sel, reg_sel, pc_inc,
    input  iram_rdata, dram_rdata,
    output iram_addr, dram_addr, dram_wdata,
    output ir, z, c, ac
  );

endinterface

// File: rtl/datapath_core_alu_unit.sv
// alu_unit: combinational AC-next (and carry-next when
// DATAPATH_CARRY_EN is defined) from alu_sel, AC and bus.
module alu_unit
  import datapath_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [7:0]        alu_sel,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] bus,
`ifdef DATAPATH_CARRY_EN
  input  logic              c,
  output logic              c_next,
`endif
  output logic [DATA_W-1:0] ac_next
);

  always_comb begin
    ac_next = ac;
    case (alu_sel)
      ALU_CLEAR: ac_next = '0;
      ALU_INC:   ac_next = ac + 1'b1;
      ALU_DEC:   ac_next = ac - 1'b1;
      ALU_ADD:   ac_next = ac + bus;
      ALU_SUB:   ac_next = ac - bus;
      ALU_MUL2:  ac_next = ac << 1;
      ALU_MUL4:  ac_next = ac << 2;
      ALU_DIV16: ac_next = ac >> 4;
      ALU_LOAD:  ac_next = bus;
      default:   ac_next = ac;
    endcase
  end

`ifdef DATAPATH_CARRY_EN
  // ADD carry: wrapped sum ends up below an operand.
  always_comb begin
    c_next = c;
    case (alu_sel)
      ALU_CLEAR: c_next = 1'b0;
      ALU_INC:   c_next = &ac;
      ALU_DEC:   c_next = ~|ac;
      ALU_ADD:   c_next = (ac + bus) < ac;
      ALU_SUB:   c_next = ac < bus;
      ALU_MUL2:  c_next = ac[DATA_W-1];
      ALU_MUL4:  c_next = ac[DATA_W-2];
      ALU_DIV16: c_next = 1'b0;
      ALU_LOAD:  c_next = 1'b0;
      default:   c_next = c;
    endcase
  end
`endif

endmodule

// File: rtl/datapath_core.sv
// datapath_core: AC/IR/PC + general registers, bus mux, ALU.
// Define DATAPATH_CARRY_EN to build the carry flag.
module datapath_core
  import datapath_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic          clk,
  input logic          reset_n,
  datapath_core_if.slave dp
);

  logic [DATA_W-1:0] rf_q [RS_IR:RS_AR];
  logic [DATA_W-1:0] ac_q;
  logic [DATA_W-1:0] ac_next;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] bus;

  always_comb begin
    bus = '0;
    case (dp.bus_sel)
      BUS_DRAM: bus = dp.dram_rdata;
      BUS_IRAM: bus = dp.iram_rdata;
      BUS_DI:   bus = rf_q[RS_DI];
      BUS_RI:   bus = rf_q[RS_RI];
      BUS_BI:   bus = rf_q[RS_BI];
      BUS_S:    bus = rf_q[RS_S];
      BUS_C1:   bus = rf_q[RS_C1];
      BUS_C2:   bus = rf_q[RS_C2];
      BUS_AR:   bus = rf_q[RS_AR];
      BUS_AC:   bus = ac_q;
      BUS_PC:   bus = DATA_W'(pc_q);
      BUS_IR:   bus = rf_q[RS_IR];
      default:  bus = '0;
    endcase
  end

`ifdef DATAPATH_CARRY_EN
  logic c_q;
  logic c_next;

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .alu_sel (dp.alu_sel),
    .ac      (ac_q),
    .bus     (bus),
    .c       (c_q),
    .c_next  (c_next),
    .ac_next (ac_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) c_q <= 1'b0;
    else          c_q <= c_next;
  end

  assign dp.c = c_q;
`else
  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .alu_sel (dp.alu_sel),
    .ac      (ac_q),
    .bus     (bus),
    .ac_next (ac_next)
  );

  assign dp.c = 1'b0;
`endif

  // PC load beats increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = RS_IR; i <= RS_AR; i++)
        rf_q[i] <= '0;
      ac_q <= '0;
      pc_q <= '0;
    end else begin
      for (int i = RS_IR; i <= RS_AR; i++)
        if (dp.reg_sel[i]) rf_q[i] <= bus;
      ac_q <= ac_next;
      if (dp.reg_sel[RS_PC])
        pc_q <= bus[ADDR_W-1:0];
      else if (dp.pc_inc)
        pc_q <= pc_q + 1'b1;
    end
  end

  assign dp.iram_addr  = pc_q;
  assign dp.dram_addr  = rf_q[RS_AR][ADDR_W-1:0];
  assign dp.dram_wdata = bus;
  assign dp.ir         = 32'(rf_q[RS_IR]);
  assign dp.z          = (ac_q == '0);
  assign dp.ac         = ac_q;

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: directed plus random control words
// against a behavioural datapath model.
module tb_datapath_core;

  logic clk;
  logic reset_n;

  datapath_core_if #(.DATA_W(32), .ADDR_W(8)) dp_if ();

  datapath_core #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dp      (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // model: rf index = reg_sel bit (0 IR .. 7 AR)
  logic [31:0] m_ac;
  logic [31:0] m_rf [8];
  logic [7:0]  m_pc;
  logic        m_c;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ac = 0;
    m_pc = 0;
    m_c  = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endtask

  function automatic logic [31:0] m_bus(input int s);
    if (s == 0) return dp_if.dram_rdata;
    if (s == 1) return dp_if.iram_rdata;
    if (s >= 2 && s <= 7) return m_rf[s-1];
    if (s == 8) return m_rf[7];
    if (s == 9) return m_ac;
    if (s == 10) return {24'd0, m_pc};
    if (s == 11) return m_rf[0];
    return 0;
  endfunction

  task automatic m_clock();
    longint a, b, r;
    logic [31:0] bv;
    int op;
    bit cu;
    bit nc;
    bv = m_bus(int'(dp_if.bus_sel));
    a  = longint'(m_ac);
    b  = longint'(bv);
    op = int'(dp_if.alu_sel);
    r  = a;
    cu = 1;
    nc = 0;
    case (op)
      0: r = 0;
      1: begin r = a + 1; nc = r[32]; end
      2: begin r = a - 1; nc = r < 0; end
      3: begin r = a + b; nc = r[32]; end
      4: begin r = a - b; nc = r < 0; end
      5: begin r = a * 2; nc = r[32]; end
      6: begin r = a * 4; nc = r[32]; end
      7: r = a / 16;
      8: r = b;
      default: cu = 0;
    endcase
    m_ac = r[31:0];
`ifdef DATAPATH_CARRY_EN
    if (cu) m_c = nc;
`else
    m_c = 0;
`endif
    for (int i = 0; i < 8; i++)
      if (dp_if.reg_sel[i]) m_rf[i] = bv;
    if (dp_if.reg_sel[8]) m_pc = bv[7:0];
    else if (dp_if.pc_inc) m_pc = m_pc + 8'd1;
  endtask

  task automatic check_state(input string t);
    check({t, "_ac"}, dp_if.ac, m_ac);
    check({t, "_z"}, dp_if.z, m_ac == 0);
    check({t, "_c"}, dp_if.c, m_c);
    check({t, "_pc"}, dp_if.iram_addr, m_pc);
    check({t, "_da"}, dp_if.dram_addr, m_rf[7][7:0]);
    check({t, "_ir"}, dp_if.ir, m_rf[0]);
  endtask

  // called at a falling edge; returns at the next one
  task automatic apply(input logic [7:0] a,
                       input logic [7:0] bs,
                       input logic [8:0] rs,
                       input logic pi,
                       input logic [31:0] id,
                       input logic [31:0] dd,
                       input string t);
    dp_if.alu_sel    = a;
    dp_if.bus_sel    = bs;
    dp_if.reg_sel    = rs;
    dp_if.pc_inc     = pi;
    dp_if.iram_rdata = id;
    dp_if.dram_rdata = dd;
    #1;
    check({t, "_bus"}, dp_if.dram_wdata, m_bus(int'(bs)));
    @(posedge clk);
    m_clock();
    #1;
    check_state(t);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [7:0]  ra;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    dp_if.alu_sel    = 8'd9;
    dp_if.bus_sel    = 8'd0;
    dp_if.reg_sel    = 9'd0;
    dp_if.pc_inc     = 1'b0;
    dp_if.iram_rdata = 32'd0;
    dp_if.dram_rdata = 32'd0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_ac", dp_if.ac, 0);
    check("rst_z", dp_if.z, 1);
    check("rst_c", dp_if.c, 0);
    check("rst_ia", dp_if.iram_addr, 0);
    check("rst_da", dp_if.dram_addr, 0);
    check("rst_ir", dp_if.ir, 0);
    reset_n = 1'b1;

    apply(8, 1, 0, 0, 32'h5, 0, "ld5");
    check("tp_ac5", dp_if.ac, 5);
    check("tp_z0", dp_if.z, 0);
    apply(4, 1, 0, 0, 32'h5, 0, "sub5");
    check("tp_ac0", dp_if.ac, 0);
    check("tp_z1", dp_if.z, 1);

    apply(8, 1, 0, 0, 32'hFFFF_FFFF, 0, "ldff");
    apply(1, 0, 0, 0, 0, 0, "incff");
    check("tp_incac", dp_if.ac, 0);
    check("tp_incz", dp_if.z, 1);
`ifdef DATAPATH_CARRY_EN
    check("tp_incc", dp_if.c, 1);
`else
    check("tp_incc", dp_if.c, 0);
`endif

    apply(9, 1, 9'h100, 0, 32'hFF, 0, "pcff");
    apply(9, 0, 0, 1, 0, 0, "pcwrap");
    check("tp_pcwrap", dp_if.iram_addr, 0);
    apply(9, 1, 9'h100, 1, 32'h42, 0, "pcld");
    check("tp_pcld", dp_if.iram_addr, 8'h42);

    apply(8, 1, 0, 0, 32'h35, 0, "ld35");
    apply(9, 9, 9'h080, 0, 0, 0, "ar");
    apply(9, 9, 9'h002, 0, 0, 0, "di");
    check("tp_da35", dp_if.dram_addr, 8'h35);
    apply(7, 2, 0, 0, 0, 0, "div16");
    check("tp_di35", dp_if.dram_wdata, 32'h35);
    check("tp_div", dp_if.ac, 3);

    apply(9, 8'h20, 9'h008, 0, 32'h77, 32'h77, "bi0");
    apply(8, 1, 0, 0, 32'h81, 0, "ld81");
    apply(6, 4, 0, 0, 0, 0, "mul4");
    check("tp_bi0", dp_if.dram_wdata, 0);
    check("tp_mul4", dp_if.ac, 32'h204);

    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      if ($urandom_range(0, 7) == 0) rd = 32'hFFFF_FFFF;
      ra = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) ra = 8'($urandom);
      apply(ra, 8'($urandom_range(0, 13)),
            9'($urandom), 1'($urandom),
            rd, $urandom, "rnd");
    end

    apply(8, 1, 9'h100, 0, 32'h1234, 0, "pre1");
    apply(9, 1, 9'h100, 0, 32'h10, 0, "pre2");
    check("pre_ac", dp_if.ac, 32'h1234);
    check("pre_pc", dp_if.iram_addr, 8'h10);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check("mid_ac", dp_if.ac, 0);
    check("mid_pc", dp_if.iram_addr, 0);
    check("mid_z", dp_if.z, 1);
    check_state("mid");
    @(negedge clk);
    reset_n = 1'b1;
    apply(8, 1, 0, 1, 32'h9, 0, "post");
    check("post_ac", dp_if.ac, 9);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
# datapath_core

Register, bus and accumulator datapath executing the control word issued each cycle by the microcoded control unit. Holds AC, IR, PC and the seven general registers, drives the shared bus, computes ALU results into AC, and exposes the instruction-RAM and data-RAM address/data ports. Sits directly downstream of the control unit and feeds back `IR` and `z` to it.

## Interface
- `DATA_W`, 32: width of bus, AC and general registers.
- `ADDR_W`, 8: width of PC and of the AR-derived data-RAM address.
- `clk`  in  1  system clock; all registers capture on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_sel`  in  8  ALU op: 0 CLEAR, 1 INC, 2 DEC, 3 ADD, 4 SUB, 5 MUL2, 6 MUL4, 7 DIV16, 8 LOAD, 9 NOP.
- `bus_sel`  in  8  bus source: 0 DRAM, 1 IRAM, 2 DI, 3 RI, 4 BI, 5 S, 6 C1, 7 C2, 8 AR, 9 AC, 10 PC, 11 IR.
- `reg_sel`  in  9  one-hot load enables: bit0 IR, 1 DI, 2 RI, 3 BI, 4 S, 5 C1, 6 C2, 7 AR, 8 PC.
- `pc_inc`  in  1  PC increment request.
- `iram_rdata`  in  DATA_W  instruction-RAM read data.
- `dram_rdata`  in  DATA_W  data-RAM read data.
- `iram_addr`  out  ADDR_W  = PC.
- `dram_addr`  out  ADDR_W  = AR[ADDR_W-1:0].
- `dram_wdata`  out  DATA_W  = current bus value.
- `ir`  out  32  IR, zero-extended/truncated to 32 bits.
- `z`  out  1  high when AC == 0.
- `c`  out  1  carry/borrow flag (see Configuration).
- `ac`  out  DATA_W  AC value, for debug/observation.

## Operation
- Bus: combinational mux on `bus_sel`; undefined codes (12..255) drive 0.
- Register loads: every reg_sel bit set loads its register from bus at the edge; multiple bits set all load simultaneously. reg_sel = 0 holds all.
- PC: load (reg_sel[8]) wins over `pc_inc`; else `pc_inc` adds 1 modulo 2^ADDR_W (0xFF -> 0x00); PC loads bus[ADDR_W-1:0].
- AC per alu_sel: CLEAR 0; INC AC+1; DEC AC-1; ADD AC+bus; SUB AC-bus; MUL2 AC<<1; MUL4 AC<<2; DIV16 logical AC>>4; LOAD bus; NOP hold; codes 10..255 hold. All results modulo 2^DATA_W.
- AC and register writes in the same cycle are independent; a register loaded with bus=AC receives the pre-edge AC.
- `z` combinational from registered AC, so it reflects AC one edge after the ALU op.
- Reset: AC, IR, PC, DI, RI, BI, S, C1, C2, AR, c = 0. Hence iram_addr = 0, dram_addr = 0, ir = 0, z = 1, ac = 0.
- Reset asserted mid-operation clears all state immediately regardless of clock; first load occurs on the first rising edge after deassertion.

## Timing
- Control inputs change on falling edge; datapath samples on rising edge, giving a half-cycle setup window.
- Bus, dram_wdata, dram_addr, iram_addr: combinational from registers/selects, zero latency.
- Register/AC/PC update latency: 1 rising edge. `z`, `c` valid same cycle as new AC.
- IRAM/DRAM read data must be stable on the bus by the rising edge of the cycle whose reg_sel/alu_sel consumes it; this block adds no wait states.

## Configuration
- `DATAPATH_CARRY_EN` defined: `c` updates on INC/ADD (carry out of bit DATA_W-1), DEC/SUB (borrow), MUL2/MUL4 (last bit shifted out of MSB); CLEAR/LOAD/DIV16 clear it; NOP holds.
- Undefined: `c` tied to 0, no carry logic synthesised.

## Structure
- Shared package: ALU op codes, bus source codes, reg_sel bit indices (shared with the control unit), DATA_W/ADDR_W defaults.
- One sub-module: `alu_unit` (combinational AC-next and carry-next from alu_sel, AC, bus); registers and bus mux stay in the top.

## Test plan
- Reset_n low mid-run with AC=0x1234, PC=0x10 -> AC=0, PC=0, z=1 immediately, before next clock.
- iram_rdata=0x5, bus_sel=1, alu_sel=8 -> AC=5, z=0; then alu_sel=4 with bus_sel=1 -> AC=0, z=1.
- AC=0xFFFFFFFF, alu_sel=1 -> AC=0, z=1, c=1 with DATAPATH_CARRY_EN, c=0 without.
- PC=0xFF, pc_inc=1 -> PC=0x00; pc_inc=1 with reg_sel=0x100, bus=0x42 -> PC=0x42.
- AC=0x35, bus_sel=9, reg_sel=0x80 then 0x02 -> AR=0x35, DI=0x35, dram_addr=0x35; alu_sel=7 -> AC=0x3.
- bus_sel=0x20, reg_sel=0x08 -> BI=0; AC=0x81, alu_sel=6 -> AC=0x204.
